// File: rtl/lsu_mem.sv
// Multi-cycle load/store unit placed after the execute stage.
// Non-memory instructions pass straight through to the register file.
// Loads and stores run over a request/response data-memory bus, using an
// IDLE -> REQ -> RSP -> DONE sequence. Misaligned accesses skip the bus and
// go straight to DONE.
//
// Ports:
//   ls_clk_i / ls_rst_i       clock, async active-high reset
//   ls_valid_i .. ls_rs2_i    instruction fields from execute
//   ls_reg_wen_o/waddr/wdata  register-file writeback
//   ls_stall_o                hold PC and upstream instruction
//   ls_done_o / misalign/fault one-cycle completion status pulses
//   mem_req_* / mem_rsp_*     data-memory request/response bus
module lsu_mem #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic          ls_clk_i,
  input  logic          ls_rst_i,
  input  logic          ls_valid_i,
  input  logic          ls_reg_wen_i,
  input  logic [AW-1:0] ls_reg_waddr_i,
  input  logic [DW-1:0] ls_aluresult_i,
  input  logic          ls_mem_wen_i,
  input  logic          ls_mem_ren_i,
  input  logic [2:0]    ls_mem_mask_i,
  input  logic [DW-1:0] ls_rs2_i,
  output logic          ls_reg_wen_o,
  output logic [AW-1:0] ls_reg_waddr_o,
  output logic [DW-1:0] ls_reg_wdata_o,
  output logic          ls_stall_o,
  output logic          ls_done_o,
  output logic          ls_misalign_o,
  output logic          ls_fault_o,
  output logic          mem_req_valid_o,
  input  logic          mem_req_ready_i,
  output logic          mem_req_we_o,
  output logic [DW-1:0] mem_req_addr_o,
  output logic [DW-1:0] mem_req_wdata_o,
  output logic [7:0]    mem_req_wstrb_o,
  input  logic          mem_rsp_valid_i,
  input  logic [DW-1:0] mem_rsp_rdata_i,
  input  logic          mem_rsp_err_i
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RSP, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] addr_q, wdata_q, rdata_q;
  logic [2:0]    mask_q;
  logic [7:0]    wstrb_q;
  logic [AW-1:0] waddr_q;
  logic          we_q, rwen_q, mis_q, err_q;

  logic          memop;
  logic          accept;
  logic [2:0]    off_i;
  logic          mis_i;
  logic [7:0]    strb_base;
  logic [7:0]    strb_i;
  logic [DW-1:0] ld_shift;
  logic [DW-1:0] ld_data;
  logic          sx;

  assign memop  = ls_valid_i & (ls_mem_ren_i | ls_mem_wen_i);
  assign accept = (state_q == S_IDLE) & memop;
  assign off_i  = ls_aluresult_i[2:0];

  always_comb begin
    mis_i     = 1'b0;
    strb_base = 8'h01;
    case (ls_mem_mask_i[1:0])
      2'd0: begin mis_i = 1'b0;          strb_base = 8'h01; end
      2'd1: begin mis_i = off_i[0];      strb_base = 8'h03; end
      2'd2: begin mis_i = |off_i[1:0];   strb_base = 8'h0F; end
      default: begin mis_i = |off_i;     strb_base = 8'hFF; end
    endcase
  end

  assign strb_i = strb_base << off_i;

  always_ff @(posedge ls_clk_i or posedge ls_rst_i) begin
    if (ls_rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      mask_q  <= '0;
      wstrb_q <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
      rwen_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= ls_aluresult_i;
        wdata_q <= ls_rs2_i << {off_i, 3'b000};
        wstrb_q <= ls_mem_wen_i ? strb_i : 8'h00;
        mask_q  <= ls_mem_mask_i;
        waddr_q <= ls_reg_waddr_i;
        we_q    <= ls_mem_wen_i;
        rwen_q  <= ls_reg_wen_i;
        mis_q   <= mis_i;
        err_q   <= 1'b0;
      end
      if ((state_q == S_RSP) && mem_rsp_valid_i) begin
        rdata_q <= mem_rsp_rdata_i;
        err_q   <= mem_rsp_err_i;
      end
    end
  end

  // Load extraction: shift the addressed lane down, then truncate and extend.
  assign ld_shift = rdata_q >> {addr_q[2:0], 3'b000};
  assign sx       = ~mask_q[2];

  always_comb begin
    ld_data = ld_shift;
    case (mask_q[1:0])
      2'd0:    ld_data = {{(DW-8){sx & ld_shift[7]}}, ld_shift[7:0]};
      2'd1:    ld_data = {{(DW-16){sx & ld_shift[15]}}, ld_shift[15:0]};
      2'd2:    ld_data = {{(DW-32){sx & ld_shift[31]}}, ld_shift[31:0]};
      default: ld_data = ld_shift;
    endcase
  end

  assign mem_req_valid_o = (state_q == S_REQ);
  assign mem_req_addr_o  = {addr_q[DW-1:3], 3'b000};
  assign mem_req_wdata_o = wdata_q;
  // Direction and strobes are only meaningful while a request is up.
  assign mem_req_we_o    = (state_q == S_REQ) & we_q;
  assign mem_req_wstrb_o = (state_q == S_REQ) ? wstrb_q : 8'h00;

  always_comb begin
    state_d        = state_q;
    ls_stall_o     = 1'b0;
    ls_done_o      = 1'b0;
    ls_misalign_o  = 1'b0;
    ls_fault_o     = 1'b0;
    ls_reg_wen_o   = 1'b0;
    ls_reg_waddr_o = ls_reg_waddr_i;
    ls_reg_wdata_o = ls_aluresult_i;
    case (state_q)
      S_IDLE: begin
        if (memop) begin
          ls_stall_o = 1'b1;
          state_d    = mis_i ? S_DONE : S_REQ;
        end else begin
          ls_reg_wen_o = ls_valid_i & ls_reg_wen_i;
        end
      end
      S_REQ: begin
        ls_stall_o = 1'b1;
        if (mem_req_ready_i) state_d = S_RSP;
      end
      S_RSP: begin
        ls_stall_o = 1'b1;
        if (mem_rsp_valid_i) state_d = S_DONE;
      end
      default: begin
        ls_done_o      = 1'b1;
        ls_misalign_o  = mis_q;
        ls_fault_o     = err_q;
        ls_reg_waddr_o = waddr_q;
        ls_reg_wdata_o = ld_data;
        ls_reg_wen_o   = rwen_q & ~we_q & ~err_q & ~mis_q;
        state_d        = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_mem.sv
module tb_lsu_mem;
  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid, rwen_i, mwen, mren;
  logic [AW-1:0] waddr_i;
  logic [DW-1:0] alu, rs2;
  logic [2:0]    mask;
  logic          reg_wen_o;
  logic [AW-1:0] reg_waddr_o;
  logic [DW-1:0] reg_wdata_o;
  logic          stall, done, misal, fault;
  logic          req_valid, req_ready, req_we;
  logic [DW-1:0] req_addr, req_wdata;
  logic [7:0]    req_wstrb;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lsu_mem #(.DW(DW), .AW(AW)) dut (
    .ls_clk_i(clk), .ls_rst_i(rst), .ls_valid_i(valid), .ls_reg_wen_i(rwen_i),
    .ls_reg_waddr_i(waddr_i), .ls_aluresult_i(alu), .ls_mem_wen_i(mwen),
    .ls_mem_ren_i(mren), .ls_mem_mask_i(mask), .ls_rs2_i(rs2),
    .ls_reg_wen_o(reg_wen_o), .ls_reg_waddr_o(reg_waddr_o), .ls_reg_wdata_o(reg_wdata_o),
    .ls_stall_o(stall), .ls_done_o(done), .ls_misalign_o(misal), .ls_fault_o(fault),
    .mem_req_valid_o(req_valid), .mem_req_ready_i(req_ready), .mem_req_we_o(req_we),
    .mem_req_addr_o(req_addr), .mem_req_wdata_o(req_wdata), .mem_req_wstrb_o(req_wstrb),
    .mem_rsp_valid_i(rsp_valid), .mem_rsp_rdata_i(rsp_rdata), .mem_rsp_err_i(rsp_err)
  );

  // Observations recorded by run_op
  int            o_stall, o_done, o_done_cyc, o_req_cyc;
  logic          o_timeout, o_unstable, o_wen, o_mis, o_fault, o_we;
  logic          o_post_done, o_post_stall, o_post_req;
  logic [DW-1:0] o_wdata, o_req_addr, o_req_wdata;
  logic [AW-1:0] o_waddr;
  logic [7:0]    o_wstrb;

  task automatic bus_idle();
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
  endtask

  task automatic clear_instr();
    valid = 1'b0; rwen_i = 1'b0; mwen = 1'b0; mren = 1'b0;
    waddr_i = '0; alu = '0; rs2 = '0; mask = '0;
  endtask

  // Present one instruction and act as the memory: ready after rdy waiting
  // REQ cycles, response rsp cycles after the cycle following the handshake.
  task automatic run_op(input logic we, input logic re, input logic [2:0] m,
                        input logic [DW-1:0] a, input logic [DW-1:0] d,
                        input logic rw, input logic [AW-1:0] wa,
                        input int rdy, input int rsp,
                        input logic [DW-1:0] rd, input logic e);
    int req_wait, rsp_wait;
    logic pend, seen, fin;
    req_wait = 0; rsp_wait = 0; pend = 0; seen = 0; fin = 0;
    o_stall = 0; o_done = 0; o_done_cyc = -1; o_req_cyc = 0;
    o_timeout = 0; o_unstable = 0; o_wen = 0; o_mis = 0; o_fault = 0; o_we = 0;
    o_wdata = '0; o_req_addr = '0; o_req_wdata = '0; o_waddr = '0; o_wstrb = '0;
    @(negedge clk);
    valid = 1'b1; mwen = we; mren = re; mask = m; alu = a; rs2 = d;
    rwen_i = rw; waddr_i = wa;
    for (int c = 0; c < 40 && !fin; c++) begin
      req_ready = req_valid && (req_wait >= rdy);
      rsp_valid = pend && (rsp_wait >= rsp);
      rsp_rdata = rsp_valid ? rd : '0;
      rsp_err   = rsp_valid ? e : 1'b0;
      #1;
      if (stall) o_stall++;
      if (req_valid) begin
        o_req_cyc++;
        if (!seen) begin
          seen = 1; o_req_addr = req_addr; o_req_wdata = req_wdata;
          o_wstrb = req_wstrb; o_we = req_we;
        end else if (req_addr !== o_req_addr || req_wdata !== o_req_wdata ||
                     req_wstrb !== o_wstrb || req_we !== o_we) begin
          o_unstable = 1;
        end
      end
      if (done) begin
        o_done++; o_done_cyc = c; o_wen = reg_wen_o; o_wdata = reg_wdata_o;
        o_waddr = reg_waddr_o; o_mis = misal; o_fault = fault; fin = 1;
      end
      if (rsp_valid) pend = 0;
      else if (pend) rsp_wait++;
      if (req_valid && req_ready) begin pend = 1; rsp_wait = 0; end
      else if (req_valid) req_wait++;
      @(negedge clk);
    end
    if (!fin) o_timeout = 1;
    clear_instr();
    bus_idle();
    #1;
    o_post_done = done; o_post_stall = stall; o_post_req = req_valid;
  endtask

  task automatic test_reset();
    clear_instr(); bus_idle();
    rst = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL rst_req_valid got=%b exp=0", req_valid); end
    n_cmp++; if (req_we !== 1'b0) begin n_bad++; $display("FAIL rst_req_we got=%b exp=0", req_we); end
    n_cmp++; if (req_wstrb !== 8'h00) begin n_bad++; $display("FAIL rst_wstrb got=%h exp=00", req_wstrb); end
    n_cmp++; if ({done, misal, fault} !== 3'b000) begin n_bad++; $display("FAIL rst_status got=%b exp=000", {done, misal, fault}); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall got=%b exp=0", stall); end
    valid = 1'b1; rwen_i = 1'b1; alu = 64'hDEAD; waddr_i = 5'd3;
    #1;
    n_cmp++; if (reg_wen_o !== 1'b1) begin n_bad++; $display("FAIL rst_pass_wen got=%b exp=1", reg_wen_o); end
    n_cmp++; if (reg_wdata_o !== 64'hDEAD) begin n_bad++; $display("FAIL rst_pass_wdata got=%h exp=dead", reg_wdata_o); end
    n_cmp++; if (reg_waddr_o !== 5'd3) begin n_bad++; $display("FAIL rst_pass_waddr got=%0d exp=3", reg_waddr_o); end
    clear_instr();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    @(negedge clk);
    valid = 1'b0; rwen_i = 1'b1; alu = 64'h77; waddr_i = 5'd9;
    #1;
    n_cmp++; if (reg_wen_o !== 1'b0) begin n_bad++; $display("FAIL pass_novalid_wen got=%b exp=0", reg_wen_o); end
    valid = 1'b1;
    #1;
    n_cmp++; if (reg_wen_o !== 1'b1 || stall !== 1'b0) begin n_bad++; $display("FAIL pass_wen_stall got=%b%b exp=10", reg_wen_o, stall); end
    clear_instr();
  endtask

  task automatic test_load_word();
    run_op(1'b0, 1'b1, 3'b010, 64'h1004, '0, 1'b1, 5'd10, 0, 0, 64'h80000000_12345678, 1'b0);
    n_cmp++; if (o_done_cyc !== 3) begin n_bad++; $display("FAIL lw_done_cycle got=%0d exp=3", o_done_cyc); end
    n_cmp++; if (o_stall !== 3) begin n_bad++; $display("FAIL lw_stall_cycles got=%0d exp=3", o_stall); end
    n_cmp++; if (o_req_addr !== 64'h1000) begin n_bad++; $display("FAIL lw_req_addr got=%h exp=1000", o_req_addr); end
    n_cmp++; if (o_wstrb !== 8'h00 || o_we !== 1'b0) begin n_bad++; $display("FAIL lw_wstrb_we got=%h/%b exp=00/0", o_wstrb, o_we); end
    n_cmp++; if (o_wdata !== 64'hFFFFFFFF_80000000) begin n_bad++; $display("FAIL lw_data got=%h exp=ffffffff80000000", o_wdata); end
    n_cmp++; if (o_wen !== 1'b1 || o_waddr !== 5'd10) begin n_bad++; $display("FAIL lw_wen_waddr got=%b/%0d exp=1/10", o_wen, o_waddr); end
    n_cmp++; if (o_post_done !== 1'b0 || o_post_stall !== 1'b0) begin n_bad++; $display("FAIL lw_after_done got=%b%b exp=00", o_post_done, o_post_stall); end
    run_op(1'b0, 1'b1, 3'b110, 64'h1004, '0, 1'b1, 5'd11, 0, 0, 64'h80000000_12345678, 1'b0);
    n_cmp++; if (o_wdata !== 64'h00000000_80000000) begin n_bad++; $display("FAIL lwu_data got=%h exp=0000000080000000", o_wdata); end
  endtask

  task automatic test_load_sizes();
    logic [DW-1:0] rd;
    rd = 64'hAABBCCDD_EEFF1122;
    run_op(1'b0, 1'b1, 3'b100, 64'h2003, '0, 1'b1, 5'd1, 0, 0, rd, 1'b0);
    n_cmp++; if (o_wdata !== 64'hEE) begin n_bad++; $display("FAIL lbu_data got=%h exp=ee", o_wdata); end
    run_op(1'b0, 1'b1, 3'b000, 64'h2003, '0, 1'b1, 5'd1, 0, 0, rd, 1'b0);
    n_cmp++; if (o_wdata !== 64'hFFFFFFFF_FFFFFFEE) begin n_bad++; $display("FAIL lb_data got=%h exp=ffffffffffffffee", o_wdata); end
    run_op(1'b0, 1'b1, 3'b001, 64'h2002, '0, 1'b1, 5'd2, 0, 0, rd, 1'b0);
    n_cmp++; if (o_wdata !== 64'hFFFFFFFF_FFFFEEFF) begin n_bad++; $display("FAIL lh_data got=%h exp=ffffffffffffeeff", o_wdata); end
    run_op(1'b0, 1'b1, 3'b101, 64'h2006, '0, 1'b1, 5'd2, 0, 0, rd, 1'b0);
    n_cmp++; if (o_wdata !== 64'hAABB) begin n_bad++; $display("FAIL lhu_data got=%h exp=aabb", o_wdata); end
    run_op(1'b0, 1'b1, 3'b011, 64'h2000, '0, 1'b1, 5'd0, 0, 0, rd, 1'b0);
    n_cmp++; if (o_wdata !== rd || o_wen !== 1'b1 || o_waddr !== 5'd0) begin n_bad++; $display("FAIL ld_x0 got=%h/%b/%0d exp=%h/1/0", o_wdata, o_wen, o_waddr, rd); end
  endtask

  task automatic test_store();
    run_op(1'b1, 1'b0, 3'b001, 64'h3006, 64'h12345678_9ABCBEEF, 1'b1, 5'd4, 0, 0, '0, 1'b0);
    n_cmp++; if (o_req_wdata !== 64'hBEEF0000_00000000) begin n_bad++; $display("FAIL sh_wdata got=%h exp=beef000000000000", o_req_wdata); end
    n_cmp++; if (o_wstrb !== 8'hC0 || o_we !== 1'b1) begin n_bad++; $display("FAIL sh_wstrb_we got=%h/%b exp=c0/1", o_wstrb, o_we); end
    n_cmp++; if (o_req_addr !== 64'h3000) begin n_bad++; $display("FAIL sh_addr got=%h exp=3000", o_req_addr); end
    n_cmp++; if (o_done !== 1 || o_wen !== 1'b0) begin n_bad++; $display("FAIL sh_done_wen got=%0d/%b exp=1/0", o_done, o_wen); end
    run_op(1'b1, 1'b1, 3'b010, 64'h6004, 64'h11223344_55667788, 1'b0, 5'd4, 0, 0, '0, 1'b0);
    n_cmp++; if (o_req_wdata !== 64'h55667788_00000000 || o_wstrb !== 8'hF0 || o_we !== 1'b1) begin n_bad++; $display("FAIL sw_lane got=%h/%h/%b exp=5566778800000000/f0/1", o_req_wdata, o_wstrb, o_we); end
  endtask

  task automatic test_backpressure();
    run_op(1'b0, 1'b1, 3'b010, 64'h7000, '0, 1'b1, 5'd6, 2, 1, 64'h12340000_00000042, 1'b0);
    n_cmp++; if (o_stall !== 6) begin n_bad++; $display("FAIL bp_stall got=%0d exp=6", o_stall); end
    n_cmp++; if (o_done_cyc !== 6 || o_done !== 1) begin n_bad++; $display("FAIL bp_done got=%0d@%0d exp=1@6", o_done, o_done_cyc); end
    n_cmp++; if (o_req_cyc !== 3 || o_unstable !== 1'b0) begin n_bad++; $display("FAIL bp_req got=%0d/%b exp=3/0", o_req_cyc, o_unstable); end
    n_cmp++; if (o_wdata !== 64'h42 || o_post_done !== 1'b0) begin n_bad++; $display("FAIL bp_data got=%h/%b exp=42/0", o_wdata, o_post_done); end
    n_cmp++; if (o_timeout !== 1'b0) begin n_bad++; $display("FAIL bp_timeout got=%b exp=0", o_timeout); end
  endtask

  task automatic test_misalign();
    run_op(1'b0, 1'b1, 3'b011, 64'h4004, '0, 1'b1, 5'd8, 0, 0, 64'h1, 1'b0);
    n_cmp++; if (o_done_cyc !== 1 || o_mis !== 1'b1) begin n_bad++; $display("FAIL ld_mis got=%0d/%b exp=1/1", o_done_cyc, o_mis); end
    n_cmp++; if (o_req_cyc !== 0 || o_wen !== 1'b0 || o_fault !== 1'b0) begin n_bad++; $display("FAIL ld_mis_side got=%0d/%b/%b exp=0/0/0", o_req_cyc, o_wen, o_fault); end
    n_cmp++; if (o_stall !== 1) begin n_bad++; $display("FAIL ld_mis_stall got=%0d exp=1", o_stall); end
    run_op(1'b1, 1'b0, 3'b001, 64'h3001, 64'hFFFF, 1'b0, 5'd0, 0, 0, '0, 1'b0);
    n_cmp++; if (o_mis !== 1'b1 || o_req_cyc !== 0) begin n_bad++; $display("FAIL sh_mis got=%b/%0d exp=1/0", o_mis, o_req_cyc); end
  endtask

  task automatic test_fault();
    run_op(1'b0, 1'b1, 3'b010, 64'h5000, '0, 1'b1, 5'd12, 0, 0, 64'h5, 1'b1);
    n_cmp++; if (o_fault !== 1'b1 || o_mis !== 1'b0) begin n_bad++; $display("FAIL err_flags got=%b/%b exp=1/0", o_fault, o_mis); end
    n_cmp++; if (o_wen !== 1'b0 || o_done_cyc !== 3) begin n_bad++; $display("FAIL err_wen got=%b@%0d exp=0@3", o_wen, o_done_cyc); end
  endtask

  task automatic test_reset_midflight();
    // Reset while in REQ: request must drop without waiting for a clock
    @(negedge clk);
    valid = 1'b1; mren = 1'b1; mask = 3'b010; alu = 64'h1008; rwen_i = 1'b1; waddr_i = 5'd5;
    @(negedge clk); #1;
    n_cmp++; if (req_valid !== 1'b1) begin n_bad++; $display("FAIL mid_req_up got=%b exp=1", req_valid); end
    clear_instr();
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (req_valid !== 1'b0) begin n_bad++; $display("FAIL mid_req_async got=%b exp=0", req_valid); end
    @(negedge clk);
    rst = 1'b0;
    // Reset while in RSP, then a late response
    @(negedge clk);
    valid = 1'b1; mren = 1'b1; mask = 3'b010; alu = 64'h1008; rwen_i = 1'b1; waddr_i = 5'd5;
    req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    clear_instr(); req_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (stall !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL mid_rsp_rst got=%b%b exp=00", stall, done); end
    @(negedge clk);
    rst = 1'b0;
    rsp_valid = 1'b1; rsp_rdata = 64'h99;
    #1;
    n_cmp++; if (done !== 1'b0 || reg_wen_o !== 1'b0 || req_valid !== 1'b0) begin n_bad++; $display("FAIL late_rsp got=%b%b%b exp=000", done, reg_wen_o, req_valid); end
    @(negedge clk);
    bus_idle();
    valid = 1'b1; rwen_i = 1'b1; alu = 64'h42; waddr_i = 5'd7;
    #1;
    n_cmp++; if (done !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL add_stall got=%b%b exp=00", done, stall); end
    n_cmp++; if (reg_wen_o !== 1'b1 || reg_wdata_o !== 64'h42 || reg_waddr_o !== 5'd7) begin n_bad++; $display("FAIL add_pass got=%b/%h/%0d exp=1/42/7", reg_wen_o, reg_wdata_o, reg_waddr_o); end
    @(negedge clk); #1;
    n_cmp++; if (req_valid !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL add_next got=%b%b exp=00", req_valid, stall); end
    clear_instr();
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_word();
    test_load_sizes();
    test_store();
    test_backpressure();
    test_misalign();
    test_fault();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
